// File: rtl/nn_spi_pkg.sv
// Shared definitions for the neural-network SPI master: width defaults,
// frame length helper, R/W encoding, FSM state type and register map.
package nn_spi_pkg;

   localparam int SPI_ADDR_WIDTH_DEF = 7;
   localparam int SPI_DATA_WIDTH_DEF = 32;
   localparam int CLK_DIV_DEF        = 2;
   localparam int NUM_NEURONS        = 4;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam logic [6:0] ADDR_NN_RESET   = 7'h00;
   localparam logic [6:0] ADDR_SPIKES_IN  = 7'h01;
   localparam logic [6:0] ADDR_SPIKES_OUT = 7'h02;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } nn_spi_state_e;

   // Total serial bits in one frame: R/W flag, address, data.
   function automatic int frame_bits(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/nn_spi_clkgen.sv
// Half-period divider for the SPI clock. While enabled it walks through
// alternating high/low half-periods of CLK_DIV clk cycles each, starting
// with a high half. Strobes mark the last clk cycle of each half:
//   fall_stb_o / sample_stb_o : last cycle of a high half (sclk about to fall)
//   rise_stb_o                : last cycle of a low half  (sclk about to rise)
// Disabling returns the divider to the start of a high half.
module nn_spi_clkgen
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic rise_stb_o,
   output logic fall_stb_o,
   output logic sample_stb_o
);

   localparam int               DIV_W    = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] cnt_q;
   logic             hi_q;
   logic             half_end;

   assign half_end     = en_i && (cnt_q == DIV_LAST);
   assign fall_stb_o   = half_end && hi_q;
   assign sample_stb_o = half_end && hi_q;
   assign rise_stb_o   = half_end && !hi_q;

   // Count clk cycles within the current half and flip phase at its end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         hi_q  <= 1'b1;
      end else if (!en_i) begin
         cnt_q <= '0;
         hi_q  <= 1'b1;
      end else if (cnt_q == DIV_LAST) begin
         cnt_q <= '0;
         hi_q  <= !hi_q;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/nn_spi_master.sv
// SPI master (mode 0) for the neural-network register peripheral.
// One command per frame: {rw, addr, data} shifted MSB first under ss_n.
// Reads capture miso during the data bits and return them on rsp_valid.
// Optional build macro NN_SPI_MASTER_STATS_EN adds txn_count/rd_count.
//
// Handshake: cmd_valid/cmd_ready is a plain valid/ready pair; a command is
// taken on the clk edge where both are high. cmd_ready is high only in IDLE,
// so all cmd_* inputs are ignored while a frame is in flight.
module nn_spi_master
   import nn_spi_pkg::*;
#(
   parameter int SPI_ADDR_WIDTH = SPI_ADDR_WIDTH_DEF,
   parameter int SPI_DATA_WIDTH = SPI_DATA_WIDTH_DEF,
   parameter int CLK_DIV        = CLK_DIV_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_rw,
   input  logic [SPI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [SPI_DATA_WIDTH-1:0] cmd_wdata,
   output logic                      rsp_valid,
   output logic [SPI_DATA_WIDTH-1:0] rsp_rdata,
   output logic                      busy,
   output logic                      sclk,
   output logic                      ss_n,
   output logic                      mosi,
   input  logic                      miso,
`ifdef NN_SPI_MASTER_STATS_EN
   output logic [15:0]               txn_count,
   output logic [15:0]               rd_count,
`endif
   output nn_spi_state_e             dbg_state
);

   localparam int               FRAME_BITS = frame_bits(SPI_ADDR_WIDTH, SPI_DATA_WIDTH);
   localparam int               BIT_W      = $clog2(FRAME_BITS + 1);
   localparam int               DIV_W      = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BITS_DONE  = BIT_W'(FRAME_BITS);
   localparam logic [BIT_W-1:0] DATA_START = BIT_W'(SPI_ADDR_WIDTH + 1);

   nn_spi_state_e             state_q;
   logic [FRAME_BITS-1:0]     tx_q;
   logic [SPI_DATA_WIDTH-1:0] rx_q;
   logic [SPI_DATA_WIDTH-1:0] rsp_rdata_q;
   logic [SPI_DATA_WIDTH-1:0] rsp_rdata_d;
   logic [BIT_W-1:0]          bit_cnt_q;
   logic [DIV_W-1:0]          wait_q;
   logic                      rw_q;
   logic                      ss_n_q;
   logic                      sclk_q;
   logic                      busy_q;
   logic                      rsp_valid_q;
   logic                      rx_bit;
   logic                      rise_stb;
   logic                      fall_stb;
   logic                      sample_stb;

   nn_spi_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (state_q == SHIFT),
      .rise_stb_o   (rise_stb),
      .fall_stb_o   (fall_stb),
      .sample_stb_o (sample_stb)
   );

   assign cmd_ready = (state_q == IDLE);
   assign busy      = busy_q;
   assign sclk      = sclk_q;
   assign ss_n      = ss_n_q;
   assign mosi      = tx_q[FRAME_BITS-1];
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign dbg_state = state_q;

   // Write frames force the captured bit to 0 so a floating miso never leaks in.
   always_comb begin
      rx_bit      = (rw_q == RW_READ) && miso;
      rsp_rdata_d = (rw_q == RW_READ) ? rx_q : '0;
   end

   // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         rsp_rdata_q <= '0;
         bit_cnt_q   <= '0;
         wait_q      <= '0;
         rw_q        <= RW_WRITE;
         ss_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  tx_q      <= {cmd_rw, cmd_addr, (cmd_rw == RW_READ) ? '0 : cmd_wdata};
                  rw_q      <= cmd_rw;
                  rx_q      <= '0;
                  bit_cnt_q <= '0;
                  wait_q    <= '0;
                  ss_n_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= SETUP;
               end
            end
            SETUP: begin
               if (wait_q == DIV_LAST) begin
                  wait_q  <= '0;
                  sclk_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            SHIFT: begin
               // bit_cnt_q is the index of the bit on the wire until it falls.
               if (sample_stb && (bit_cnt_q >= DATA_START)) begin
                  rx_q <= {rx_q[SPI_DATA_WIDTH-2:0], rx_bit};
               end
               if (fall_stb) begin
                  sclk_q    <= 1'b0;
                  tx_q      <= {tx_q[FRAME_BITS-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
               if (rise_stb) begin
                  if (bit_cnt_q == BITS_DONE) begin
                     state_q <= HOLD;
                  end else begin
                     sclk_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (wait_q == DIV_LAST) begin
                  wait_q      <= '0;
                  ss_n_q      <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rsp_rdata_d;
                  state_q     <= GAP;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            GAP: begin
               if (wait_q == DIV_LAST) begin
                  wait_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef NN_SPI_MASTER_STATS_EN
   logic [15:0] txn_q;
   logic [15:0] rd_q;

   assign txn_count = txn_q;
   assign rd_count  = rd_q;

   // Count completed frames (all, and reads only); both wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txn_q <= '0;
         rd_q  <= '0;
      end else if (rsp_valid_q) begin
         txn_q <= txn_q + 16'd1;
         if (rw_q == RW_READ) begin
            rd_q <= rd_q + 16'd1;
         end
      end
   end
`endif

endmodule
